dlx_exec_alu: RTL and testbench
===============================

# dlx_exec_alu

Execute stage of the DLX integer pipeline, directly downstream of the operand preprocessor. Consumes the registered ALU operands, operation code, shift amount and arithmetic/shift enables, and produces a registered 32-bit result with carry and zero flags. Arithmetic/logic operations complete in one cycle. Shifts run on a serial one-bit-per-cycle shifter with a busy stall back to the preprocessor.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk1  input  1  pipeline clock; all state updates on the rising edge.
- rst1  input  1  reset, asynchronous and active-high.
- aluin1  input  32  operand A; the shift source for shifts.
- aluin2  input  32  operand B.
- op  input  3  operation select within the class.
- opsel  input  3  class code; informational only, not decoded here.
- shift_nos  input  5  shift amount, 0..31.
- en_ar  input  1  arithmetic/logic request, sampled each edge.
- en_sh  input  1  shift request, sampled each edge.
- aluout  output  32  registered result; holds its value between results.
- carry  output  1  registered carry/last-shifted-out bit.
- zero  output  1  registered; 1 when the result just written is 0.
- result_valid  output  1  one-cycle pulse when aluout/carry/zero update.
- busy  output  1  high while a serial shift is in progress; upstream holds its outputs.

## Operation
- Reset values: aluout=0, carry=0, zero=0, result_valid=0, busy=0, FSM=IDLE, shift counter=0.
- FSM states: IDLE, SHIFT.
- In IDLE, en_ar=1 has priority over en_sh. Both low: result_valid=0 and all outputs hold.
- Arithmetic ops, by op: 000 ADD, 001 SUB (A + ~B + 1), 010 AND, 011 OR, 100 XOR, 101 SLT signed (result 1 or 0), 110 SLTU unsigned, 111 pass B.
- Carry for arithmetic ops:
  - ADD: bit 32 of the 33-bit sum.
  - SUB: bit 32 of A + ~B + 1, so 1 means no borrow.
  - All other ops: 0.
- Shift ops, by op: 000 SLL, 001 SRL, 010 SRA (sign fill). Codes 011–111 pass A unshifted with carry=0, completing as a zero-amount shift.
- Shift with shift_nos=0: completes in one cycle; aluout=A, carry=0.
- Shift with shift_nos=N≥1:
  - On acceptance: load A into the shift register, load N into the counter, set busy=1, enter SHIFT.
  - Each SHIFT cycle shifts one bit and decrements the counter.
  - The edge on which the counter goes 1→0 writes aluout, sets carry to the bit shifted out on that edge, pulses result_valid, clears busy, and returns to IDLE.
- zero is computed from the value written into aluout.
- While busy=1, en_ar and en_sh are ignored. Upstream must not change its outputs until busy falls.
- rst1 asserted mid-shift: aborts immediately to reset values, with no result_valid.

## Timing
- Arithmetic, or shift with N=0, request sampled at edge E0: aluout/carry/zero updated and result_valid=1 after E0. Latency 1.
- Serial shift with N≥1, accepted at E0: busy=1 after E0. Result, result_valid=1 and busy=0 after edge EN. Latency N cycles, occupancy N+1 edges including E0.
- A new request may be accepted on the same edge busy is seen low, i.e. the edge after EN.
- Back-to-back arithmetic requests give one result per cycle, with result_valid held high.

## Configuration
- DLX_EXEC_BARREL_EN defined:
  - Shifts use a combinational barrel shifter and complete in one cycle, like arithmetic ops.
  - busy is tied to 0 and the SHIFT state is not built.
  - carry is the last bit shifted out: bit 32−N of A for SLL, bit N−1 of A for SRL/SRA, 0 for N=0.
- Undefined: serial shifter as described above.
- Results and flags are identical in both builds; only latency differs.

## Test plan
- Async reset: assert rst1 between edges → all outputs 0 immediately. Repeat mid-shift (SLL, N=20, after 5 cycles) → busy=0 at once, no result_valid.
- ADD 0xFFFFFFFF+0x00000001 → aluout=0, carry=1, zero=1, valid 1 cycle after request. SUB 5−7 → aluout=0xFFFFFFFE, carry=0.
- SLT A=0x80000000, B=1 → 1; SLTU with the same operands → 0.
- SRA A=0x80000001, N=4:
  - Serial build: busy high 4 cycles, result 0xF8000000, carry=0, valid pulse 4 cycles after acceptance.
  - BARREL build: same values, latency 1.
- SLL A=0x80000000, N=1 → 0, carry=1, zero=1. SRL with N=0 → aluout=A, carry=0, latency 1.
- During a busy shift, pulse en_ar with ADD → ignored. Hold the ADD until busy falls → accepted the next edge, two distinct valid pulses.

Source files
------------

// File: rtl/dlx_exec_alu.sv
// -----------------------------------------------------------------------------
// dlx_exec_alu -- DLX execute stage: single-cycle ALU plus a shifter.
//
// Arithmetic/logic operations finish in one cycle. By default, shifts use a
// serial shifter that moves one bit per cycle. While it runs, busy is high and
// upstream must hold its outputs. If DLX_EXEC_BARREL_EN is defined, a
// combinational barrel shifter is used instead. Every shift then takes one
// cycle and busy is tied low. Both builds give the same results and flags.
//
// Ports:
//   clk1          pipeline clock, rising edge
//   rst1          asynchronous active-high reset
//   aluin1        operand A (shift source)
//   aluin2        operand B
//   op            operation select within the class
//   opsel         class code, not decoded here
//   shift_nos     shift amount 0..31
//   en_ar         arithmetic/logic request (has priority over en_sh)
//   en_sh         shift request
//   aluout        registered result, holds between results
//   carry         registered carry / last bit shifted out
//   zero          registered, 1 when the value just written is 0
//   result_valid  one-cycle pulse when aluout/carry/zero update
//   busy          high while a serial shift is in progress
// -----------------------------------------------------------------------------
module dlx_exec_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             rst1,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  input  logic [2:0]       op,
  input  logic [2:0]       opsel,
  input  logic [4:0]       shift_nos,
  input  logic             en_ar,
  input  logic             en_sh,
  output logic [WIDTH-1:0] aluout,
  output logic             carry,
  output logic             zero,
  output logic             result_valid,
  output logic             busy
);

  // opsel is carried alongside the operands but carries no meaning here.
  logic unused_opsel;
  assign unused_opsel = ^opsel;

  // ---------------------------------------------------------------------------
  // Arithmetic / logic unit
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] ar_result;
  logic             ar_carry;

  assign sum_add = {1'b0, aluin1} + {1'b0, aluin2};
  // Subtraction as A + ~B + 1, so the carry-out means "no borrow".
  assign sum_sub = {1'b0, aluin1} + {1'b0, ~aluin2} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    ar_result = '0;
    ar_carry  = 1'b0;
    case (op)
      3'b000: begin
        ar_result = sum_add[WIDTH-1:0];
        ar_carry  = sum_add[WIDTH];
      end
      3'b001: begin
        ar_result = sum_sub[WIDTH-1:0];
        ar_carry  = sum_sub[WIDTH];
      end
      3'b010: ar_result = aluin1 & aluin2;
      3'b011: ar_result = aluin1 | aluin2;
      3'b100: ar_result = aluin1 ^ aluin2;
      3'b101: ar_result = {{(WIDTH-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
      3'b110: ar_result = {{(WIDTH-1){1'b0}}, (aluin1 < aluin2)};
      default: ar_result = aluin2;
    endcase
  end

  // Shift codes 011..111 are not real shifts: they pass A through with carry 0.
  logic real_shift;
  assign real_shift = ~op[2] & ~(op[1] & op[0]);

  // Write port into the output registers, driven by whichever shifter is built.
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             wr_carry;

`ifdef DLX_EXEC_BARREL_EN
  // ---------------------------------------------------------------------------
  // Barrel shifter: every request completes in one cycle.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] barrel_val;
  logic             barrel_carry;
  logic [4:0]       sll_idx;
  logic [4:0]       srl_idx;

  // The last bit shifted out is A[32-N] for a left shift and A[N-1] for a
  // right shift. Both indices wrap for N=0, but that case is forced to 0 below.
  assign sll_idx = ~shift_nos + 5'd1;
  assign srl_idx = shift_nos - 5'd1;

  always_comb begin
    barrel_val   = aluin1;
    barrel_carry = 1'b0;
    case (op)
      3'b000: begin
        barrel_val   = aluin1 << shift_nos;
        barrel_carry = aluin1[sll_idx];
      end
      3'b001: begin
        barrel_val   = aluin1 >> shift_nos;
        barrel_carry = aluin1[srl_idx];
      end
      3'b010: begin
        barrel_val   = $signed(aluin1) >>> shift_nos;
        barrel_carry = aluin1[srl_idx];
      end
      default: begin
        barrel_val   = aluin1;
        barrel_carry = 1'b0;
      end
    endcase
    if (shift_nos == 5'd0) begin
      barrel_carry = 1'b0;
    end
  end

  always_comb begin
    wr_en    = en_ar | en_sh;
    wr_val   = en_ar ? ar_result : barrel_val;
    wr_carry = en_ar ? ar_carry  : barrel_carry;
  end

  assign busy = 1'b0;

  // real_shift only matters to the serial shifter.
  logic unused_real_shift;
  assign unused_real_shift = real_shift;

`else
  // ---------------------------------------------------------------------------
  // Serial shifter: one bit per cycle under a two-state FSM.
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [4:0]       cnt_reg, cnt_next;
  logic [1:0]       shop_reg, shop_next;   // latched shift kind (SLL/SRL/SRA)
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  logic accept_ar, accept_sh, sh_start;

  assign accept_ar = (state_reg == IDLE) & en_ar;
  assign accept_sh = (state_reg == IDLE) & ~en_ar & en_sh;
  // Only a real shift with a non-zero amount needs the multi-cycle path.
  assign sh_start  = accept_sh & real_shift & (shift_nos != 5'd0);

  // A single one-bit step of the held shift register.
  always_comb begin
    step_val = shift_reg;
    step_out = 1'b0;
    case (shop_reg)
      2'b00: begin
        step_val = {shift_reg[WIDTH-2:0], 1'b0};
        step_out = shift_reg[WIDTH-1];
      end
      2'b01: begin
        step_val = {1'b0, shift_reg[WIDTH-1:1]};
        step_out = shift_reg[0];
      end
      default: begin
        step_val = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
        step_out = shift_reg[0];
      end
    endcase
  end

  // State register
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= 5'd0;
      shop_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      shop_reg  <= shop_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sh_start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == 5'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_en      = 1'b0;
    wr_val     = ar_result;
    wr_carry   = 1'b0;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    shop_next  = shop_reg;
    case (state_reg)
      IDLE: begin
        if (accept_ar) begin
          wr_en    = 1'b1;
          wr_val   = ar_result;
          wr_carry = ar_carry;
        end else if (sh_start) begin
          shift_next = aluin1;
          cnt_next   = shift_nos;
          shop_next  = op[1:0];
        end else if (accept_sh) begin
          // Zero-amount or non-shift code: A passes through at once.
          wr_en    = 1'b1;
          wr_val   = aluin1;
          wr_carry = 1'b0;
        end
      end
      SHIFT: begin
        shift_next = step_val;
        cnt_next   = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          wr_en    = 1'b1;
          wr_val   = step_val;
          wr_carry = step_out;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_reg == SHIFT);
`endif

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] aluout_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             valid_reg;

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      aluout_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= wr_en;
      if (wr_en) begin
        aluout_reg <= wr_val;
        carry_reg  <= wr_carry;
        zero_reg   <= (wr_val == '0);
      end
    end
  end

  assign aluout       = aluout_reg;
  assign carry        = carry_reg;
  assign zero         = zero_reg;
  assign result_valid = valid_reg;

endmodule

// File: tb/tb_dlx_exec_alu.sv
// -----------------------------------------------------------------------------
// tb_dlx_exec_alu -- self-checking bench for dlx_exec_alu.
// A table of vectors is driven one at a time. Each expected result goes into a
// scoreboard queue together with the cycle on which it is due. A monitor pops
// and compares entries on every result_valid pulse. Hand-written sequences
// cover reset, abort mid-shift, requests while busy, and back-to-back traffic.
// -----------------------------------------------------------------------------
module tb_dlx_exec_alu;

`ifdef DLX_EXEC_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk1;
  logic        rst1;
  logic [31:0] aluin1, aluin2;
  logic [2:0]  op, opsel;
  logic [4:0]  shift_nos;
  logic        en_ar, en_sh;
  logic [31:0] aluout;
  logic        carry, zero, result_valid, busy;

  dlx_exec_alu #(.WIDTH(32)) dut (
    .clk1(clk1), .rst1(rst1), .aluin1(aluin1), .aluin2(aluin2), .op(op),
    .opsel(opsel), .shift_nos(shift_nos), .en_ar(en_ar), .en_sh(en_sh),
    .aluout(aluout), .carry(carry), .zero(zero),
    .result_valid(result_valid), .busy(busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    string       name;
    logic        sh;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  n;
    logic [31:0] exp_out;
    logic        exp_c;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        c;
    logic        z;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endfunction

  task automatic add_vec(string nm, logic sh, logic [2:0] o, logic [31:0] a,
                         logic [31:0] b, logic [4:0] n, logic [31:0] eo, logic ec);
    vec_t v;
    v.name = nm; v.sh = sh; v.op = o; v.a = a; v.b = b; v.n = n;
    v.exp_out = eo; v.exp_c = ec;
    vecs.push_back(v);
  endtask

  task automatic push_exp(string nm, logic [31:0] eo, logic ec, int due);
    exp_t e;
    e.name = nm; e.out = eo; e.c = ec; e.z = (eo == 32'd0); e.due = due;
    sb.push_back(e);
  endtask

  // Bounded wait for busy to drop, sampled on falling edges.
  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 64) begin
      @(negedge clk1);
      k++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_busy_timeout got=%b required=0", nm, busy);
    end
  endtask

  task automatic issue(vec_t v);
    int lat;
    @(negedge clk1);
    aluin1 = v.a; aluin2 = v.b; op = v.op; shift_nos = v.n;
    en_ar = ~v.sh; en_sh = v.sh;
    lat = (v.sh && !BARREL && v.n != 0 && v.op <= 3'd2) ? int'(v.n) : 0;
    push_exp(v.name, v.exp_out, v.exp_c, cyc + 1 + lat);
    @(negedge clk1);
    en_ar = 1'b0; en_sh = 1'b0;
    wait_idle(v.name);
  endtask

  // Monitor: samples 1 ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk1);
      cyc++;
      #1;
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid got aluout=%h at cycle %0d required no result", aluout, cyc);
        end else begin
          e = sb.pop_front();
          $display("[TB] %s aluout=%h carry=%0d zero=%0d cycle=%0d", e.name, aluout, carry, zero, cyc);
          chk({e.name, "_out"},   aluout, e.out);
          chk({e.name, "_carry"}, 32'(carry), 32'(e.c));
          chk({e.name, "_zero"},  32'(zero),  32'(e.z));
          chk({e.name, "_cycle"}, 32'(cyc),   32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int due_sra;

    // Arithmetic / logic vectors
    add_vec("add_wrap", 0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1);
    add_vec("add_ovf",  0, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0);
    add_vec("sub_neg",  0, 3'b001, 32'd5,         32'd7,         0, 32'hFFFF_FFFE, 0);
    add_vec("sub_pos",  0, 3'b001, 32'd7,         32'd5,         0, 32'h0000_0002, 1);
    add_vec("and",      0, 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'h00F0_00F0, 0);
    add_vec("or",       0, 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'hFFF0_FFF0, 0);
    add_vec("xor",      0, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'hFF00_FF00, 0);
    add_vec("slt",      0, 3'b101, 32'h8000_0000, 32'h0000_0001, 0, 32'h0000_0001, 0);
    add_vec("sltu",     0, 3'b110, 32'h8000_0000, 32'h0000_0001, 0, 32'h0000_0000, 0);
    add_vec("slt_m1",   0, 3'b101, 32'd5,         32'hFFFF_FFFF, 0, 32'h0000_0000, 0);
    add_vec("sltu_m1",  0, 3'b110, 32'd5,         32'hFFFF_FFFF, 0, 32'h0000_0001, 0);
    add_vec("passb",    0, 3'b111, 32'd123,       32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
    // Shift vectors
    add_vec("sra4",     1, 3'b010, 32'h8000_0001, 32'd0, 5'd4,  32'hF800_0000, 0);
    add_vec("sll1",     1, 3'b000, 32'h8000_0000, 32'd0, 5'd1,  32'h0000_0000, 1);
    add_vec("srl0",     1, 3'b001, 32'h1234_5678, 32'd0, 5'd0,  32'h1234_5678, 0);
    add_vec("srl1",     1, 3'b001, 32'h8000_0001, 32'd0, 5'd1,  32'h4000_0000, 1);
    add_vec("sll31",    1, 3'b000, 32'h0000_0003, 32'd0, 5'd31, 32'h8000_0000, 1);
    add_vec("sra31",    1, 3'b010, 32'h7FFF_FFFF, 32'd0, 5'd31, 32'h0000_0000, 1);
    add_vec("sh_pass",  1, 3'b101, 32'hCAFE_F00D, 32'd0, 5'd7,  32'hCAFE_F00D, 0);
    add_vec("srl3",     1, 3'b001, 32'hF000_0000, 32'd0, 5'd3,  32'h1E00_0000, 0);
    add_vec("sll2",     1, 3'b000, 32'h0000_0001, 32'd0, 5'd2,  32'h0000_0004, 0);

    rst1 = 1'b1; aluin1 = '0; aluin2 = '0; op = '0; opsel = 3'b001;
    shift_nos = '0; en_ar = 1'b0; en_sh = 1'b0;

    // Reset state
    #12;
    chk("rst_aluout", aluout, 32'd0);
    chk("rst_carry",  32'(carry), 32'd0);
    chk("rst_zero",   32'(zero),  32'd0);
    chk("rst_valid",  32'(result_valid), 32'd0);
    chk("rst_busy",   32'(busy),  32'd0);
    @(negedge clk1);
    rst1 = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);

    // Asynchronous reset between edges while a result is showing
    @(negedge clk1);
    aluin1 = 32'hFFFF_FFFF; aluin2 = 32'd3; op = 3'b000; en_ar = 1'b1;
    push_exp("add_pre_rst", 32'd2, 1'b1, cyc + 1);
    @(posedge clk1);
    #3;
    rst1 = 1'b1;
    #1;
    chk("arst_aluout", aluout, 32'd0);
    chk("arst_carry",  32'(carry), 32'd0);
    chk("arst_valid",  32'(result_valid), 32'd0);
    @(negedge clk1);
    en_ar = 1'b0;
    rst1  = 1'b0;

    // Reset in the middle of a long shift
    @(negedge clk1);
    aluin1 = 32'hFFFF_FFFF; op = 3'b000; shift_nos = 5'd20; en_sh = 1'b1;
    if (BARREL) push_exp("sll20", 32'hFFF0_0000, 1'b1, cyc + 1);
    @(negedge clk1);
    en_sh = 1'b0;
    repeat (5) @(negedge clk1);
    chk("midshift_busy", 32'(busy), BARREL ? 32'd0 : 32'd1);
    #2;
    rst1 = 1'b1;
    #1;
    chk("midshift_rst_busy",  32'(busy), 32'd0);
    chk("midshift_rst_valid", 32'(result_valid), 32'd0);
    chk("midshift_rst_out",   aluout, 32'd0);
    @(negedge clk1);
    rst1 = 1'b0;
    repeat (25) @(negedge clk1);

`ifndef DLX_EXEC_BARREL_EN
    // Requests while busy: a short pulse is ignored, a held one lands next edge
    @(negedge clk1);
    aluin1 = 32'h8000_0001; aluin2 = 32'd1; op = 3'b010; shift_nos = 5'd4;
    en_sh = 1'b1; en_ar = 1'b0;
    due_sra = cyc + 1 + 4;
    push_exp("sra4_busy", 32'hF800_0000, 1'b0, due_sra);
    @(negedge clk1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    en_sh = 1'b0; op = 3'b000; en_ar = 1'b1;
    @(negedge clk1);
    en_ar = 1'b0;
    @(negedge clk1);
    en_ar = 1'b1;
    push_exp("add_held", 32'h8000_0002, 1'b0, due_sra + 1);
    wait_idle("held");
    @(negedge clk1);
    en_ar = 1'b0;
`endif

    // Back-to-back arithmetic, result_valid held high
    @(negedge clk1);
    op = 3'b000; aluin1 = 32'd1; aluin2 = 32'd1; en_ar = 1'b1;
    push_exp("b2b_add1", 32'd2, 1'b0, cyc + 1);
    @(negedge clk1);
    aluin1 = 32'd2;
    push_exp("b2b_add2", 32'd3, 1'b0, cyc + 1);
    @(negedge clk1);
    op = 3'b001; aluin1 = 32'd2; aluin2 = 32'd2;
    push_exp("b2b_sub", 32'd0, 1'b1, cyc + 1);
    @(negedge clk1);
    en_ar = 1'b0;

    repeat (10) @(negedge clk1);
    chk("drain_pending", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
